// File: rtl/if_stage.sv
// if_stage: instruction fetch stage with a single-cycle fetch into the IF/ID register.
//
// Ports:
//   clk            - single clock, all state updates on the rising edge
//   reset          - asynchronous active-high reset
//   stall          - hazard stall from decode; holds pc and IF/ID
//   flush          - squash the instruction being fetched this cycle
//   branch_taken   - redirect pc to branch_target (wins over jump)
//   branch_target  - 13-bit word address of branch destination
//   jump           - redirect pc to jump_target
//   jump_target    - 13-bit word address of jump destination
//   instruction    - combinational instruction-memory read data for address pc
//   pc             - current fetch address, straight from the PC register
//   if_id_instr    - registered instruction handed to decode
//   if_id_pc_next  - registered pc+1 of that instruction
//   if_id_valid    - registered; 1 when if_id_instr is a real instruction
//   halted         - registered; 1 once fetch has stopped on a halt word
module if_stage #(
  parameter logic [12:0] RESET_PC   = 13'h0000,
  parameter logic [15:0] NOP_INSTR  = 16'h0000,
  parameter logic [15:0] HALT_INSTR = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [12:0] branch_target,
  input  logic        jump,
  input  logic [12:0] jump_target,
  input  logic [15:0] instruction,
  output logic [12:0] pc,
  output logic [15:0] if_id_instr,
  output logic [12:0] if_id_pc_next,
  output logic        if_id_valid,
  output logic        halted
);

  typedef enum logic {RUN, HALT} state_t;

  state_t      state_q, state_d;
  logic [12:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [12:0] pcNext_q, pcNext_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [12:0] target;
  logic [12:0] pcPlusOne;

  // Branch has priority over jump when both arrive in the same cycle.
  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? branch_target : jump_target;
  // 13-bit add wraps 13'h1FFF back to 13'h0000 naturally.
  assign pcPlusOne = pc_q + 13'd1;

  // State, PC and IF/ID register; reset forces everything to a bubble at RESET_PC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      instr_q  <= NOP_INSTR;
      pcNext_q <= 13'h0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pcNext_q <= pcNext_d;
      valid_q  <= valid_d;
    end
  end

  // Next-state logic. Everything holds by default, which is exactly the
  // stall behaviour; each branch below only overrides what it changes.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcNext_d = pcNext_q;
    valid_d  = valid_q;

    case (state_q)
      RUN: begin
        if (redirect) begin
          // Redirect beats stall and flush: the fetched word is on the wrong path.
          pc_d     = target;
          instr_d  = NOP_INSTR;
          pcNext_d = 13'h0000;
          valid_d  = 1'b0;
        end else if (flush) begin
          instr_d  = NOP_INSTR;
          pcNext_d = 13'h0000;
          valid_d  = 1'b0;
          if (!stall) begin
            pc_d = pcPlusOne;
          end
        end else if (!stall) begin
          instr_d  = instruction;
          pcNext_d = pcPlusOne;
          valid_d  = 1'b1;
          if (instruction == HALT_INSTR) begin
            // The halt word itself goes down the pipe; pc stays parked on it.
            state_d = HALT;
          end else begin
            pc_d = pcPlusOne;
          end
        end
      end
      HALT: begin
        // Only reset leaves HALT; all control inputs are ignored here.
        instr_d  = NOP_INSTR;
        pcNext_d = 13'h0000;
        valid_d  = 1'b0;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  assign pc            = pc_q;
  assign if_id_instr   = instr_q;
  assign if_id_pc_next = pcNext_q;
  assign if_id_valid   = valid_q;
  assign halted        = (state_q == HALT);

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed self-checking bench for if_stage with a small
// instruction-memory model driving the instruction input from pc.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        branchTaken;
  logic [12:0] branchTarget;
  logic        jump;
  logic [12:0] jumpTarget;
  logic [15:0] instruction;
  logic [12:0] pc;
  logic [15:0] ifIdInstr;
  logic [12:0] ifIdPcNext;
  logic        ifIdValid;
  logic        halted;

  logic [15:0] mem [0:8191];

  int testsRun;
  int testsFailed;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .flush         (flush),
    .branch_taken  (branchTaken),
    .branch_target (branchTarget),
    .jump          (jump),
    .jump_target   (jumpTarget),
    .instruction   (instruction),
    .pc            (pc),
    .if_id_instr   (ifIdInstr),
    .if_id_pc_next (ifIdPcNext),
    .if_id_valid   (ifIdValid),
    .halted        (halted)
  );

  // Combinational instruction memory read at the current fetch address.
  assign instruction = mem[pc];

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // Checks every output of the stage against hand-computed values.
  task automatic expectAll(input string tag, input logic [12:0] ePc, input logic [15:0] eInstr,
                           input logic [12:0] ePcNext, input logic eValid, input logic eHalted);
    checkOutput({tag, ".pc"},     {19'd0, pc},         {19'd0, ePc});
    checkOutput({tag, ".instr"},  {16'd0, ifIdInstr},  {16'd0, eInstr});
    checkOutput({tag, ".pcnext"}, {19'd0, ifIdPcNext}, {19'd0, ePcNext});
    checkOutput({tag, ".valid"},  {31'd0, ifIdValid},  {31'd0, eValid});
    checkOutput({tag, ".halted"}, {31'd0, halted},     {31'd0, eHalted});
  endtask

  // Sets the control inputs, then lets one rising edge pass and settles 1 time unit after it.
  task automatic applyStimulus(input logic s, input logic f, input logic b, input logic [12:0] bT,
                               input logic j, input logic [12:0] jT);
    stall        = s;
    flush        = f;
    branchTaken  = b;
    branchTarget = bT;
    jump         = j;
    jumpTarget   = jT;
    @(posedge clk);
    #1;
  endtask

  initial begin
    testsRun    = 0;
    testsFailed = 0;

    for (int i = 0; i < 8192; i++) mem[i] = 16'h0000;
    for (int i = 0; i < 9; i++) mem[i] = 16'h1001 + 16'(i);
    mem[9]       = 16'hFFFF;
    mem[13'h010] = 16'hA010;
    mem[13'h020] = 16'hA020;
    mem[13'h040] = 16'hA040;
    mem[13'h1FFF] = 16'hBFFF;

    reset        = 1'b1;
    stall        = 1'b0;
    flush        = 1'b0;
    branchTaken  = 1'b0;
    branchTarget = 13'h0000;
    jump         = 1'b0;
    jumpTarget   = 13'h0000;

    // Reset state is visible before any clock edge.
    #2;
    expectAll("reset", 13'h0000, 16'h0000, 13'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Sequential fetch of words 0..3, one cycle latency.
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("seq1", 13'h0001, 16'h1001, 13'h0001, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("seq2", 13'h0002, 16'h1002, 13'h0002, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("seq3", 13'h0003, 16'h1003, 13'h0003, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("seq4", 13'h0004, 16'h1004, 13'h0004, 1'b1, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("seq5", 13'h0005, 16'h1005, 13'h0005, 1'b1, 1'b0);

    // Stall at pc=5 for two cycles holds everything.
    applyStimulus(1, 0, 0, 0, 0, 0);
    expectAll("stall1", 13'h0005, 16'h1005, 13'h0005, 1'b1, 1'b0);
    applyStimulus(1, 0, 0, 0, 0, 0);
    expectAll("stall2", 13'h0005, 16'h1005, 13'h0005, 1'b1, 1'b0);

    // Branch during stall still redirects and bubbles.
    applyStimulus(1, 0, 1, 13'h0040, 0, 0);
    expectAll("brStall", 13'h0040, 16'h0000, 13'h0000, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("fetch40", 13'h0041, 16'hA040, 13'h0041, 1'b1, 1'b0);

    // Branch wins over jump.
    applyStimulus(0, 0, 1, 13'h0010, 1, 13'h0020);
    expectAll("prio", 13'h0010, 16'h0000, 13'h0000, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("fetch10", 13'h0011, 16'hA010, 13'h0011, 1'b1, 1'b0);

    // Jump alone to pc=7.
    applyStimulus(0, 0, 0, 0, 1, 13'h0007);
    expectAll("jump7", 13'h0007, 16'h0000, 13'h0000, 1'b0, 1'b0);

    // Flush with stall holds pc; flush without stall advances it.
    applyStimulus(1, 1, 0, 0, 0, 0);
    expectAll("flushStall", 13'h0007, 16'h0000, 13'h0000, 1'b0, 1'b0);
    applyStimulus(0, 1, 0, 0, 0, 0);
    expectAll("flushRun", 13'h0008, 16'h0000, 13'h0000, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("fetch8", 13'h0009, 16'h1009, 13'h0009, 1'b1, 1'b0);

    // Wrap-around from 13'h1FFF.
    applyStimulus(0, 0, 0, 0, 1, 13'h1FFF);
    expectAll("jumpTop", 13'h1FFF, 16'h0000, 13'h0000, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("wrap", 13'h0000, 16'hBFFF, 13'h0000, 1'b1, 1'b0);

    // Halt word at pc=9.
    applyStimulus(0, 0, 0, 0, 1, 13'h0009);
    expectAll("jump9", 13'h0009, 16'h0000, 13'h0000, 1'b0, 1'b0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("halt.pc",     {19'd0, pc},        {19'd0, 13'h0009});
    checkOutput("halt.instr",  {16'd0, ifIdInstr}, {16'd0, 16'hFFFF});
    checkOutput("halt.valid",  {31'd0, ifIdValid}, 32'd1);
    checkOutput("halt.halted", {31'd0, halted},    32'd1);

    // In HALT every control input is ignored.
    applyStimulus(0, 0, 0, 0, 1, 13'h0020);
    expectAll("haltJump", 13'h0009, 16'h0000, 13'h0000, 1'b0, 1'b1);
    applyStimulus(1, 1, 1, 13'h0040, 1, 13'h0020);
    expectAll("haltAll", 13'h0009, 16'h0000, 13'h0000, 1'b0, 1'b1);

    // Asynchronous reset out of HALT, observed before the next edge.
    reset = 1'b1;
    #1;
    expectAll("asyncRst", 13'h0000, 16'h0000, 13'h0000, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // First edge after reset fetches from RESET_PC.
    applyStimulus(0, 0, 0, 0, 0, 0);
    expectAll("postRst", 13'h0001, 16'h1001, 13'h0001, 1'b1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 13'h0000, PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 16'h0000, instruction word driven into IF/ID for a bubble.
REQ-003 Parameter HALT_INSTR, default 16'hFFFF, instruction word that stops fetch.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 stall  input  1  hazard stall from decode; hold PC and IF/ID.
REQ-007 flush  input  1  squash the instruction being fetched this cycle.
REQ-008 branch_taken  input  1  redirect PC to branch_target.
REQ-009 branch_target  input  13  word address of branch destination.
REQ-010 jump  input  1  redirect PC to jump_target.
REQ-011 jump_target  input  13  word address of jump destination.
REQ-012 instruction  input  16  combinational read data from instruction memory for address pc.
REQ-013 pc  output  13  current fetch address to instruction memory, driven directly from the PC register.
REQ-014 if_id_instr  output  16  registered instruction to decode.
REQ-015 if_id_pc_next  output  13  registered pc+1 of that instruction.
REQ-016 if_id_valid  output  1  registered; 1 = if_id_instr is a real instruction.
REQ-017 halted  output  1  registered; 1 = fetch stopped in HALT state.

Function
REQ-018 The block SHALL implement two states, RUN and HALT; reset enters RUN.
REQ-019 The PC SHALL be word-addressed; the increment is pc+1 modulo 8192, so 13'h1FFF wraps to 13'h0000.
REQ-020 redirect SHALL be defined as branch_taken | jump; the target SHALL be branch_target when branch_taken=1, otherwise jump_target (branch wins when both are asserted).
REQ-021 In RUN with redirect=1, the block SHALL load pc <= target and load a bubble into IF/ID (if_id_instr=NOP_INSTR, if_id_pc_next=0, if_id_valid=0), regardless of stall and flush.
REQ-022 In RUN with redirect=0 and flush=1, the block SHALL load a bubble into IF/ID; pc SHALL hold if stall=1, otherwise pc <= pc+1.
REQ-023 In RUN with redirect=0, flush=0 and stall=1, pc and all IF/ID outputs SHALL hold their values.
REQ-024 In RUN with redirect=0, flush=0, stall=0 and instruction!=HALT_INSTR, the block SHALL load if_id_instr<=instruction, if_id_pc_next<=pc+1, if_id_valid<=1, and pc<=pc+1.
REQ-025 In RUN with redirect=0, flush=0, stall=0 and instruction==HALT_INSTR, the block SHALL load the halt word into IF/ID with valid=1, hold pc, and move to HALT.
REQ-026 In HALT, pc SHALL hold, halted SHALL be 1, and IF/ID SHALL load a bubble every cycle; stall, flush, branch_taken and jump SHALL be ignored.
REQ-027 HALT SHALL be exited only by reset.
REQ-028 Fetch latency SHALL be one cycle: the instruction at address pc appears on the IF/ID outputs after the next rising edge.

Reset
REQ-029 When reset is asserted, the block SHALL immediately, without waiting for a clock edge, drive pc=RESET_PC, if_id_instr=NOP_INSTR, if_id_pc_next=0, if_id_valid=0, halted=0, and state=RUN.
REQ-030 Reset asserted mid-operation, including in HALT or during a stall, SHALL override all other inputs.
REQ-031 On the first rising edge after reset deasserts, the block SHALL perform a normal fetch from RESET_PC.

Verification
REQ-032 Sequential fetch: after reset, with memory words 0..3 = 16'h1001..16'h1004 and no control inputs -> on edges 1..4, if_id_instr=16'h1001..16'h1004, if_id_pc_next=1..4, valid=1.
REQ-033 Stall then redirect: stall=1 for 2 cycles at pc=5 -> pc and IF/ID unchanged; then branch_taken=1, branch_target=13'h0040 with stall=1 -> pc=13'h0040, valid=0; the next cycle fetches address 0x40.
REQ-034 Priority: branch_taken=1 (target 13'h0010) and jump=1 (target 13'h0020) together -> pc=13'h0010; flush=1 with stall=1 at pc=7 -> pc stays 7, valid=0.
REQ-035 Wrap-around: pc=13'h1FFF, normal fetch -> pc=13'h0000, if_id_pc_next=13'h0000.
REQ-036 Halt: fetch 16'hFFFF at pc=9 -> IF/ID holds 16'hFFFF with valid=1, halted=1, pc=9; the following cycles give valid=0 and ignore jump=1; async reset -> pc=0, halted=0 before the next edge.
